writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Registered writeback stage for the pipelined core, parametrised in data width (RV32/RV64).
- Selects the register-file write value from one of three sources: load data, link address (pc+4) or ALU result.
- Extracts and extends load data from an unshifted, naturally aligned memory word using the byte offset.
- Detects misaligned and illegal loads and suppresses their write. Drives the register-file write port and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- OFFW, 2 for XLEN=32 and 3 for XLEN=64 (log2(XLEN/8)), byte-offset width; derived, not overridden.
- CNTW, 64, retire-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  an instruction is presented this cycle
- stall  in  1  hold request; the stage captures nothing this cycle
- flush  in  1  kill the incoming instruction
- pc  in  XLEN  instruction address
- load  in  1  instruction is a load
- jal  in  1  instruction is jal or jalr (link write)
- funct3  in  3  load type
- addr_lo  in  OFFW  low bits of the load effective address
- mdata  in  XLEN  raw aligned memory word
- alu_res  in  XLEN  ALU result
- rd  in  5  destination register
- rd_we  in  1  instruction writes rd
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- wb_valid  out  1  an instruction retired or faulted in this slot
- load_fault  out  1  misaligned or illegal load; pulses one cycle
- retired  out  CNTW  count of retired instructions

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0, including retired. Deassertion takes effect at the next clk edge.
- Capture rule: accept = in_valid & ~stall & ~flush.
  - On a clk edge with accept=1, the outputs are registered from that cycle's inputs. Latency is exactly 1 cycle.
  - On a clk edge with accept=0: wb_valid, rf_we and load_fault are 0 (bubble). rf_waddr and rf_wdata hold their previous values.
  - flush has priority over stall and in_valid.
- Write-data selection, in priority order: load, then jal (pc+4, mod 2^XLEN), then alu_res.
- Load extraction: sh = mdata >> (8*addr_lo).
  - lb (0): sign-extend sh[7:0].
  - lh (1): sign-extend sh[15:0].
  - lw (2): XLEN=32 passes sh unchanged; XLEN=64 sign-extends sh[31:0].
  - lbu (4): zero-extend sh[7:0].
  - lhu (5): zero-extend sh[15:0].
  - ld (3) and lwu (6): legal only when XLEN=64. ld passes sh; lwu zero-extends sh[31:0].
- Fault conditions, on an accepted load:
  - Illegal funct3: 7 always; 3 and 6 when XLEN=32.
  - Misaligned address: halfword loads with addr_lo[0]≠0; word loads with addr_lo[1:0]≠0; ld with addr_lo≠0.
  - On a fault: load_fault=1, wb_valid=1, rf_we=0, retired unchanged. rf_wdata is don't-care but must be deterministic.
- rf_we = accept & rd_we & (rd≠0) & ~fault. rf_waddr = rd on every accept.
- retired increments by 1 on each accepted non-faulting instruction, whether or not it writes a register. It wraps from all-ones to 0.
- Simultaneous stall and flush: the result is a bubble; nothing is retained from either input.
- Reset asserted mid-operation: the pending write is lost and the counter clears; no partial write is issued.

Test Plan:
- XLEN=32, accepted lb: mdata=0x80FF7F01, addr_lo=2 → next cycle rf_wdata=0xFFFFFFFF, rf_we=1, retired=1. Same inputs as lbu → 0x000000FF.
- XLEN=32, accepted lh: mdata=0x8001_1234, addr_lo=2 → rf_wdata=0xFFFF8001. With addr_lo=1 → load_fault=1, rf_we=0, retired unchanged.
- XLEN=32, accepted jal: pc=0xFFFFFFFC, rd=1 → rf_wdata=0x00000000, rf_we=1. Same instruction with rd=0 → rf_we=0, wb_valid=1, retired increments.
- XLEN=64, accepted lw then lwu: mdata=0x00000000_F0000000, addr_lo=0 → 0xFFFFFFFF_F0000000 for lw, then 0x00000000_F0000000 for lwu. XLEN=32 with funct3=6 → load_fault=1.
- Stall/flush: in_valid=1 with stall=1 for 3 cycles, then released → exactly one rf_we pulse and retired +1. in_valid=1 with stall=1 and flush=1 → no write. Pull rst_n low mid-cycle → all outputs 0 immediately, without waiting for a clk edge.
- Counter wrap: force retired to all-ones via a CNTW=4 build with 16 retirements → retired=0. The next retirement gives 1.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: load extract/extend, result select, register-file write port.
// Registers one instruction per accepted cycle and counts retirements.
module writeback_stage #(
    parameter  int XLEN = 32,
    parameter  int CNTW = 64,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic            load,
    input  logic            jal,
    input  logic [2:0]      funct3,
    input  logic [OFFW-1:0] addr_lo,
    input  logic [XLEN-1:0] mdata,
    input  logic [XLEN-1:0] alu_res,
    input  logic [4:0]      rd,
    input  logic            rd_we,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_valid,
    output logic            load_fault,
    output logic [CNTW-1:0] retired
);

    logic            accept;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ldata;
    logic [XLEN-1:0] wdata;
    logic            illegal;
    logic            misaligned;
    logic            fault;

    assign accept = in_valid & ~stall & ~flush;
    assign sh     = mdata >> {addr_lo, 3'b000};

    always_comb begin
        ldata = sh;
        case (funct3)
            3'd0:    ldata = XLEN'($signed(sh[7:0]));
            3'd1:    ldata = XLEN'($signed(sh[15:0]));
            3'd2:    ldata = XLEN'($signed(sh[31:0]));
            3'd4:    ldata = XLEN'(sh[7:0]);
            3'd5:    ldata = XLEN'(sh[15:0]);
            3'd6:    ldata = XLEN'(sh[31:0]);
            default: ldata = sh;
        endcase
    end

    // Access size is encoded in funct3[1:0]; the unsigned bit does not matter here.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd1:    misaligned = addr_lo[0];
            2'd2:    misaligned = |addr_lo[1:0];
            2'd3:    misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = (funct3 == 3'd7) ||
                     ((XLEN == 32) && ((funct3 == 3'd3) || (funct3 == 3'd6)));
    assign fault   = load & (illegal | misaligned);

    always_comb begin
        wdata = alu_res;
        if (load) begin
            wdata = ldata;
        end else if (jal) begin
            wdata = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            wb_valid   <= 1'b0;
            load_fault <= 1'b0;
            retired    <= '0;
        end else if (accept) begin
            rf_we      <= rd_we & (rd != 5'd0) & ~fault;
            rf_waddr   <= rd;
            rf_wdata   <= wdata;
            wb_valid   <= 1'b1;
            load_fault <= fault;
            if (!fault) begin
                retired <= retired + CNTW'(1);
            end
        end else begin
            rf_we      <= 1'b0;
            wb_valid   <= 1'b0;
            load_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: RV32, RV64 and a 4-bit-counter build share one stimulus.
// Directed table, hand sequences and random traffic against a reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush, load, jal, rd_we;
    logic [2:0]  funct3, addr_lo;
    logic [63:0] pc, mdata, alu_res;
    logic [4:0]  rd;

    logic        w32_we, w32_valid, w32_fault;
    logic [4:0]  w32_waddr;
    logic [31:0] w32_wdata;
    logic [63:0] w32_ret;
    logic        w64_we, w64_valid, w64_fault;
    logic [4:0]  w64_waddr;
    logic [63:0] w64_wdata;
    logic [63:0] w64_ret;
    logic        c_we, c_valid, c_fault;
    logic [4:0]  c_waddr;
    logic [31:0] c_wdata;
    logic [3:0]  c_ret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .CNTW(64)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .flush(flush), .pc(pc[31:0]), .load(load), .jal(jal),
        .funct3(funct3), .addr_lo(addr_lo[1:0]), .mdata(mdata[31:0]),
        .alu_res(alu_res[31:0]), .rd(rd), .rd_we(rd_we),
        .rf_we(w32_we), .rf_waddr(w32_waddr), .rf_wdata(w32_wdata),
        .wb_valid(w32_valid), .load_fault(w32_fault), .retired(w32_ret)
    );

    writeback_stage #(.XLEN(64), .CNTW(64)) d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .flush(flush), .pc(pc), .load(load), .jal(jal),
        .funct3(funct3), .addr_lo(addr_lo), .mdata(mdata),
        .alu_res(alu_res), .rd(rd), .rd_we(rd_we),
        .rf_we(w64_we), .rf_waddr(w64_waddr), .rf_wdata(w64_wdata),
        .wb_valid(w64_valid), .load_fault(w64_fault), .retired(w64_ret)
    );

    writeback_stage #(.XLEN(32), .CNTW(4)) dc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .flush(flush), .pc(pc[31:0]), .load(load), .jal(jal),
        .funct3(funct3), .addr_lo(addr_lo[1:0]), .mdata(mdata[31:0]),
        .alu_res(alu_res[31:0]), .rd(rd), .rd_we(rd_we),
        .rf_we(c_we), .rf_waddr(c_waddr), .rf_wdata(c_wdata),
        .wb_valid(c_valid), .load_fault(c_fault), .retired(c_ret)
    );

    // Reference state, index 0 = RV32, index 1 = RV64
    logic        e_valid;
    logic [4:0]  e_wa;
    logic        e_fault[2];
    logic        e_we[2];
    logic [63:0] e_wd[2];
    logic        e_known[2];
    logic [63:0] e_cnt[2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_wa    = '0;
        for (int k = 0; k < 2; k++) begin
            e_fault[k] = 1'b0;
            e_we[k]    = 1'b0;
            e_wd[k]    = '0;
            e_known[k] = 1'b1;
            e_cnt[k]   = '0;
        end
    endtask

    // Load result from access size, offset and signedness in plain arithmetic
    function automatic void model(input int xl, output logic flt,
                                  output logic [63:0] val);
        logic [63:0] d, mask;
        int sz, off;
        d   = (xl == 32) ? {32'b0, mdata[31:0]} : mdata;
        off = (xl == 32) ? int'(addr_lo[1:0]) : int'(addr_lo);
        sz  = 1 << funct3[1:0];
        flt = 1'b0;
        if (load) begin
            if (funct3 == 3'd7) flt = 1'b1;
            if (xl == 32 && (sz == 8 || funct3 == 3'd6)) flt = 1'b1;
            if (off % sz != 0) flt = 1'b1;
            d    = d >> (8 * off);
            mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
            val  = d & mask;
            if (!funct3[2] && val[8 * sz - 1]) val = val | ~mask;
        end else if (jal) begin
            val = pc + 64'd4;
        end else begin
            val = alu_res;
        end
        if (xl == 32) val = val & 64'hFFFF_FFFF;
    endfunction

    task automatic check_all();
        chk("valid32", w32_valid, e_valid);
        chk("fault32", w32_fault, e_fault[0]);
        chk("we32", w32_we, e_we[0]);
        chk("waddr32", w32_waddr, e_wa);
        if (e_known[0]) chk("wdata32", w32_wdata, e_wd[0]);
        chk("ret32", w32_ret, e_cnt[0]);
        chk("valid64", w64_valid, e_valid);
        chk("fault64", w64_fault, e_fault[1]);
        chk("we64", w64_we, e_we[1]);
        chk("waddr64", w64_waddr, e_wa);
        if (e_known[1]) chk("wdata64", w64_wdata, e_wd[1]);
        chk("ret64", w64_ret, e_cnt[1]);
        chk("valid_c", c_valid, e_valid);
        chk("we_c", c_we, e_we[0]);
        chk("fault_c", c_fault, e_fault[0]);
        chk("ret_c", c_ret, e_cnt[0] & 64'hF);
    endtask

    task automatic step();
        logic        acc;
        logic        f[2];
        logic [63:0] v[2];
        acc = in_valid & ~stall & ~flush;
        model(32, f[0], v[0]);
        model(64, f[1], v[1]);
        @(posedge clk);
        #1;
        e_valid = acc;
        if (acc) e_wa = rd;
        for (int k = 0; k < 2; k++) begin
            e_fault[k] = acc & f[k];
            e_we[k]    = acc & rd_we & (rd != 5'd0) & ~f[k];
            if (acc) begin
                e_wd[k]    = v[k];
                e_known[k] = ~f[k];
                if (!f[k]) e_cnt[k] = e_cnt[k] + 64'd1;
            end
        end
        check_all();
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall = 0; flush = 0; load = 0; jal = 0; rd_we = 0;
        funct3 = 0; addr_lo = 0; pc = 0; mdata = 0; alu_res = 0; rd = 0;
    endtask

    typedef struct {
        logic        ld, jl;
        logic [2:0]  f3, off;
        logic [63:0] pcv, md, alu;
        logic [4:0]  rdv;
        logic        rwe;
        logic        we32, f32;
        logic [63:0] wd32;
        logic        we64, f64;
        logic [63:0] wd64;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{1, 0, 3'd0, 3'd2, 64'h0, 64'h80FF7F01, 64'h0, 5'd5, 1,
                   1, 0, 64'hFFFFFFFF, 1, 0, 64'hFFFFFFFF_FFFFFFFF};
        vt[1]  = '{1, 0, 3'd4, 3'd2, 64'h0, 64'h80FF7F01, 64'h0, 5'd5, 1,
                   1, 0, 64'hFF, 1, 0, 64'hFF};
        vt[2]  = '{1, 0, 3'd1, 3'd2, 64'h0, 64'h80011234, 64'h0, 5'd6, 1,
                   1, 0, 64'hFFFF8001, 1, 0, 64'hFFFFFFFF_FFFF8001};
        vt[3]  = '{1, 0, 3'd1, 3'd1, 64'h0, 64'h80011234, 64'h0, 5'd6, 1,
                   0, 1, 64'h0, 0, 1, 64'h0};
        vt[4]  = '{0, 1, 3'd0, 3'd0, 64'hFFFFFFFC, 64'h0, 64'h0, 5'd1, 1,
                   1, 0, 64'h0, 1, 0, 64'h1_00000000};
        vt[5]  = '{0, 1, 3'd0, 3'd0, 64'hFFFFFFFC, 64'h0, 64'h0, 5'd0, 1,
                   0, 0, 64'h0, 0, 0, 64'h1_00000000};
        vt[6]  = '{1, 0, 3'd2, 3'd0, 64'h0, 64'hF0000000, 64'h0, 5'd7, 1,
                   1, 0, 64'hF0000000, 1, 0, 64'hFFFFFFFF_F0000000};
        vt[7]  = '{1, 0, 3'd6, 3'd0, 64'h0, 64'hF0000000, 64'h0, 5'd7, 1,
                   0, 1, 64'h0, 1, 0, 64'h00000000_F0000000};
        vt[8]  = '{1, 0, 3'd3, 3'd0, 64'h0, 64'h11223344_55667788, 64'h0, 5'd8, 1,
                   0, 1, 64'h0, 1, 0, 64'h11223344_55667788};
        vt[9]  = '{1, 0, 3'd3, 3'd4, 64'h0, 64'h11223344_55667788, 64'h0, 5'd8, 1,
                   0, 1, 64'h0, 0, 1, 64'h0};
        vt[10] = '{0, 0, 3'd0, 3'd0, 64'h0, 64'h0, 64'h01234567_89ABCDEF, 5'd31, 1,
                   1, 0, 64'h89ABCDEF, 1, 0, 64'h01234567_89ABCDEF};
        vt[11] = '{1, 0, 3'd7, 3'd0, 64'h0, 64'h12345678, 64'h0, 5'd9, 1,
                   0, 1, 64'h0, 0, 1, 64'h0};
        vt[12] = '{1, 0, 3'd5, 3'd2, 64'h0, 64'h80011234, 64'h0, 5'd10, 1,
                   1, 0, 64'h8001, 1, 0, 64'h8001};
        vt[13] = '{1, 1, 3'd0, 3'd0, 64'h100, 64'h7F, 64'h0, 5'd11, 1,
                   1, 0, 64'h7F, 1, 0, 64'h7F};
        vt[14] = '{0, 0, 3'd0, 3'd0, 64'h0, 64'h0, 64'h55, 5'd12, 0,
                   0, 0, 64'h55, 0, 0, 64'h55};
        vt[15] = '{1, 0, 3'd0, 3'd7, 64'h0, 64'h80000000_00000000, 64'h0, 5'd13, 1,
                   1, 0, 64'h0, 1, 0, 64'hFFFFFFFF_FFFFFF80};

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            in_valid = 1; stall = 0; flush = 0;
            load = vt[i].ld; jal = vt[i].jl; funct3 = vt[i].f3;
            addr_lo = vt[i].off; pc = vt[i].pcv; mdata = vt[i].md;
            alu_res = vt[i].alu; rd = vt[i].rdv; rd_we = vt[i].rwe;
            step();
            chk("tbl_we32", w32_we, vt[i].we32);
            chk("tbl_flt32", w32_fault, vt[i].f32);
            if (!vt[i].f32) chk("tbl_wd32", w32_wdata, vt[i].wd32);
            chk("tbl_we64", w64_we, vt[i].we64);
            chk("tbl_flt64", w64_fault, vt[i].f64);
            if (!vt[i].f64) chk("tbl_wd64", w64_wdata, vt[i].wd64);
            chk("tbl_waddr", w32_waddr, vt[i].rdv);
        end

        // Three stalled cycles then release: exactly one write
        idle_inputs();
        in_valid = 1; stall = 1; rd = 5'd3; rd_we = 1; alu_res = 64'hABCD;
        repeat (3) begin
            step();
            chk("stall_we", w32_we, 1'b0);
        end
        stall = 0;
        step();
        chk("stall_rel_we", w32_we, 1'b1);
        chk("stall_rel_wd", w32_wdata, 64'hABCD);
        in_valid = 0;
        step();
        chk("stall_after_we", w32_we, 1'b0);

        // Stall plus flush leaves nothing behind
        in_valid = 1; stall = 1; flush = 1; rd = 5'd4; alu_res = 64'h77;
        step();
        chk("sf_we", w32_we, 1'b0);
        chk("sf_valid", w64_valid, 1'b0);
        in_valid = 0; stall = 0; flush = 0;
        step();
        chk("sf_after_we", w32_we, 1'b0);

        // Asynchronous reset between edges
        in_valid = 1; rd = 5'd9; alu_res = 64'h99;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", w32_we, 1'b0);
        chk("arst_valid", w64_valid, 1'b0);
        chk("arst_waddr", w32_waddr, 5'd0);
        chk("arst_wdata", w64_wdata, 64'h0);
        chk("arst_ret32", w32_ret, 64'h0);
        chk("arst_ret64", w64_ret, 64'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_we", w32_we, 1'b0);
        model_reset();
        rst_n = 1'b1;

        // Sixteen retirements wrap the 4-bit counter
        idle_inputs();
        in_valid = 1; rd_we = 1; rd = 5'd2;
        for (int i = 0; i < 16; i++) begin
            alu_res = 64'(i);
            step();
        end
        chk("wrap_zero", c_ret, 4'd0);
        chk("wrap_ret32", w32_ret, 64'd16);
        step();
        chk("wrap_one", c_ret, 4'd1);

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            load     = $urandom_range(0, 1);
            jal      = ($urandom_range(0, 3) == 0);
            funct3   = 3'($urandom_range(0, 7));
            addr_lo  = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
            pc       = {$urandom, $urandom};
            mdata    = {$urandom, $urandom};
            alu_res  = {$urandom, $urandom};
            rd       = 5'($urandom_range(0, 31));
            rd_we    = $urandom_range(0, 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
